// File: rtl/jtag_user_dr_bank.sv
// JTAG user data-register bank: a {we, addr, data} frame shifted through the TCK domain gives
// addressed read/write access to N_REGS registers. Define JTAG_LEN_CHECK_EN to reject frames whose bit count is not LEN.
module jtag_user_dr_bank #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 2,
  parameter int                    N_REGS      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sel_i,
  input  logic                         capture_i,
  input  logic                         shift_i,
  input  logic                         update_i,
  input  logic                         tdi_i,
  output logic                         tdo_o,
  input  logic [N_REGS*DATA_WIDTH-1:0] rd_data_i,
  output logic [N_REGS*DATA_WIDTH-1:0] wr_data_o,
  output logic [N_REGS-1:0]            wr_stb_o,
  output logic                         e1dr_o,
  output logic                         frame_err_o,
  output logic                         busy_o
);

  localparam int LEN     = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int N_SLOTS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] N_REGS_W = (ADDR_WIDTH + 1)'(N_REGS);

  typedef enum logic [1:0] {IDLE, SHIFT, EXIT} state_t;

  state_t                 state_reg, state_next;
  logic [LEN-1:0]         sr_reg, sr_next;
  logic [ADDR_WIDTH-1:0]  last_addr_reg, last_addr_next;
  logic                   busy_reg, e1dr_reg, frame_err_reg;
  logic                   active, capture_go, shift_go, commit_go;
  logic                   commit_we, addr_ok, len_ok, accept, wr_en, err_next;
  logic [ADDR_WIDTH-1:0]  commit_addr;
  logic [DATA_WIDTH-1:0]  commit_data;
  logic [DATA_WIDTH-1:0]  rd_slot [N_SLOTS];

  // Pad the capture mux to a full power of two so last_addr always indexes in range.
  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_rd
      if (gi < N_REGS) begin : g_used
        assign rd_slot[gi] = rd_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_pad
        assign rd_slot[gi] = '0;
      end
    end
  endgenerate

  assign active     = (state_reg == SHIFT) || (state_reg == EXIT);
  assign capture_go = sel_i && capture_i;
  assign shift_go   = sel_i && !capture_i && active && shift_i;
  assign commit_go  = sel_i && !capture_i && active && !shift_i && update_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // SHIFT and EXIT differ only in how they were entered; Pause/Exit2 all collapse into EXIT.
  always_comb begin
    state_next = state_reg;
    if (!sel_i) begin
      state_next = IDLE;
    end else if (capture_i) begin
      state_next = SHIFT;
    end else if (active) begin
      if (shift_i) begin
        state_next = SHIFT;
      end else if (update_i) begin
        state_next = IDLE;
      end else begin
        state_next = EXIT;
      end
    end
  end

  always_comb begin
    commit_we      = sr_reg[LEN-1];
    commit_addr    = sr_reg[LEN-2:DATA_WIDTH];
    commit_data    = sr_reg[DATA_WIDTH-1:0];
    addr_ok        = {1'b0, commit_addr} < N_REGS_W;
    accept         = commit_go && addr_ok && len_ok;
    wr_en          = accept && commit_we;
    err_next       = commit_go && !accept;
    last_addr_next = accept ? commit_addr : last_addr_reg;
    sr_next        = sr_reg;
    if (capture_go) begin
      sr_next = {1'b0, last_addr_reg, rd_slot[last_addr_reg]};
    end else if (shift_go) begin
      sr_next = {tdi_i, sr_reg[LEN-1:1]};
    end
  end

`ifdef JTAG_LEN_CHECK_EN
  // The bit counter only matters when frame length is enforced; it saturates one past LEN to flag overruns.
  localparam int CNT_W = $clog2(LEN + 2);
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (capture_go) begin
      cnt_next = '0;
    end else if (shift_go && (cnt_reg != CNT_W'(LEN + 1))) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign len_ok = (cnt_reg == CNT_W'(LEN));
`else
  assign len_ok = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_reg        <= '0;
      last_addr_reg <= '0;
      busy_reg      <= 1'b0;
      e1dr_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      sr_reg        <= sr_next;
      last_addr_reg <= last_addr_next;
      busy_reg      <= (state_next != IDLE);
      e1dr_reg      <= commit_go;
      frame_err_reg <= err_next;
    end
  end

  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] wr_data_reg;
      logic                  wr_stb_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          wr_data_reg <= RESET_VALUE;
          wr_stb_reg  <= 1'b0;
        end else begin
          wr_stb_reg <= wr_en && (commit_addr == ADDR_WIDTH'(gi));
          if (wr_en && (commit_addr == ADDR_WIDTH'(gi))) begin
            wr_data_reg <= commit_data;
          end
        end
      end

      assign wr_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = wr_data_reg;
      assign wr_stb_o[gi]                           = wr_stb_reg;
    end
  endgenerate

  assign tdo_o       = sr_reg[0];
  assign busy_o      = busy_reg;
  assign e1dr_o      = e1dr_reg;
  assign frame_err_o = frame_err_reg;

endmodule

// File: tb/tb_jtag_user_dr_bank.sv
// Bench for jtag_user_dr_bank: a 4-register and a 3-register instance share one TAP stimulus
// and are compared every cycle against a frame-level model, plus literal spot checks.
module tb_jtag_user_dr_bank;

  localparam int          LEN = 35;
  localparam logic [31:0] RV1 = 32'hA5A5_0003;

  logic        clk = 1'b0;
  logic        rst, sel, cap, sh, upd, tdi;
  logic [31:0] rd_regs [4];
  logic [127:0] rd0, wr0;
  logic [95:0]  rd1, wr1;
  logic [3:0]   stb0;
  logic [2:0]   stb1;
  logic         tdo0, tdo1, e1dr0, e1dr1, err0, err1, busy0, busy1;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  assign rd0 = {rd_regs[3], rd_regs[2], rd_regs[1], rd_regs[0]};
  assign rd1 = {rd_regs[2], rd_regs[1], rd_regs[0]};

  jtag_user_dr_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .N_REGS(4), .RESET_VALUE(32'h0)) dut0 (
    .clk_i(clk), .rst_i(rst), .sel_i(sel), .capture_i(cap), .shift_i(sh), .update_i(upd),
    .tdi_i(tdi), .tdo_o(tdo0), .rd_data_i(rd0), .wr_data_o(wr0), .wr_stb_o(stb0),
    .e1dr_o(e1dr0), .frame_err_o(err0), .busy_o(busy0));

  jtag_user_dr_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .N_REGS(3), .RESET_VALUE(RV1)) dut1 (
    .clk_i(clk), .rst_i(rst), .sel_i(sel), .capture_i(cap), .shift_i(sh), .update_i(upd),
    .tdi_i(tdi), .tdo_o(tdo1), .rd_data_i(rd1), .wr_data_o(wr1), .wr_stb_o(stb1),
    .e1dr_o(e1dr1), .frame_err_o(err1), .busy_o(busy1));

  // Model: per instance, the frame being built, bits shifted, whether a frame is open, and the bank.
  logic [LEN-1:0] m_frame [2];
  int             m_cnt   [2];
  bit             m_open  [2];
  int             m_last  [2];
  logic [31:0]    m_wr    [2][4];
  bit             m_e1dr  [2];
  bit             m_err   [2];
  logic [3:0]     m_stb   [2];

  function automatic int n_of(int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_frame[i] = '0; m_cnt[i] = 0; m_open[i] = 1'b0; m_last[i] = 0;
      m_e1dr[i] = 1'b0; m_err[i] = 1'b0; m_stb[i] = '0;
      for (int k = 0; k < 4; k++) m_wr[i][k] = (i == 0) ? 32'h0 : RV1;
    end
  endtask

  task automatic model_commit(int i);
    bit          we, ok;
    int          a;
    logic [31:0] d;
    we = m_frame[i][34];
    a  = int'(m_frame[i][33:32]);
    d  = m_frame[i][31:0];
    ok = (a < n_of(i));
`ifdef JTAG_LEN_CHECK_EN
    ok = ok && (m_cnt[i] == LEN);
`endif
    m_e1dr[i] = 1'b1;
    if (!ok) begin
      m_err[i] = 1'b1;
    end else begin
      m_last[i] = a;
      if (we) begin
        m_wr[i][a]  = d;
        m_stb[i][a] = 1'b1;
      end
    end
  endtask

  task automatic model_edge(bit s, bit c, bit h, bit u, bit t);
    for (int i = 0; i < 2; i++) begin
      m_e1dr[i] = 1'b0; m_err[i] = 1'b0; m_stb[i] = '0;
      if (!s) begin
        m_open[i] = 1'b0;
      end else if (c) begin
        m_frame[i] = {1'b0, 2'(m_last[i]), rd_regs[m_last[i]]};
        m_cnt[i]   = 0;
        m_open[i]  = 1'b1;
      end else if (m_open[i] && h) begin
        m_frame[i] = (m_frame[i] >> 1) | (LEN'(t) << (LEN - 1));
        if (m_cnt[i] < LEN + 1) m_cnt[i]++;
      end else if (m_open[i] && u) begin
        model_commit(i);
        m_open[i] = 1'b0;
      end
    end
  endtask

  task automatic cyc(bit s, bit c, bit h, bit u, bit t);
    sel = s; cap = c; sh = h; upd = u; tdi = t;
    @(posedge clk);
    if (!rst) model_edge(s, c, h, u, t);
    #1;
  endtask

  task automatic send(logic [39:0] bits, int n);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, bits[i]);
    cyc(1, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tdo0", tdo0, m_frame[0][0]);
      chk("tdo1", tdo1, m_frame[1][0]);
      chk("busy0", busy0, m_open[0]);
      chk("busy1", busy1, m_open[1]);
      chk("e1dr0", e1dr0, m_e1dr[0]);
      chk("e1dr1", e1dr1, m_e1dr[1]);
      chk("err0", err0, m_err[0]);
      chk("err1", err1, m_err[1]);
      chk("stb0", stb0, m_stb[0]);
      chk("stb1", stb1, m_stb[1][2:0]);
      chk("wr0", wr0, {m_wr[0][3], m_wr[0][2], m_wr[0][1], m_wr[0][0]});
      chk("wr1", wr1, {m_wr[1][2], m_wr[1][1], m_wr[1][0]});
    end
  end

  logic [34:0] v;
  logic [39:0] f;

  initial begin
    rst = 1'b1; sel = 0; cap = 0; sh = 0; upd = 0; tdi = 0;
    rd_regs[0] = 32'hDEADBEEF; rd_regs[1] = 32'h11111111;
    rd_regs[2] = 32'h22222222; rd_regs[3] = 32'h0BADCAFE;
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr1_lit", wr1, {3{RV1}});
    chk("rst_busy_lit", busy0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Capture register 0 and shift the whole frame out.
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < LEN; i++) begin
      @(negedge clk);
      v[i] = tdo0;
      cyc(1, 0, 1, 0, 0);
    end
    chk("cap_frame_lit", v, {1'b0, 2'd0, 32'hDEADBEEF});
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Write register 2; update held for two cycles must still strobe once.
    f = {5'b0, 1'b1, 2'd2, 32'h12345678};
    send(f, LEN);
    cyc(1, 0, 0, 1, 0);
    @(negedge clk);
    chk("wr2_lit", wr0[95:64], 32'h12345678);
    chk("stb_lit", stb0, 4'b0100);
    chk("e1dr_lit", e1dr0, 1'b1);
    chk("wr_other_lit", {wr0[127:96], wr0[63:0]}, 96'h0);
    cyc(1, 0, 0, 1, 0);
    @(negedge clk);
    chk("stb_once_lit", stb0, 4'b0000);
    cyc(0, 0, 0, 0, 0);

    // Read-select register 3, then capture it.
    f = {5'b0, 1'b0, 2'd3, 32'h0};
    send(f, LEN);
    cyc(1, 0, 0, 1, 0);
    @(negedge clk);
    chk("rsel_stb_lit", stb0, 4'b0000);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < LEN; i++) begin
      @(negedge clk);
      v[i] = tdo0;
      cyc(1, 0, 1, 0, 0);
    end
    chk("rsel_data_lit", v[33:0], {2'd3, 32'h0BADCAFE});
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Address 3 writes in the 4-register bank and is out of range in the 3-register bank.
    f = {5'b0, 1'b1, 2'd3, 32'hFEEDFACE};
    send(f, LEN);
    cyc(1, 0, 0, 1, 0);
    @(negedge clk);
    chk("oor_err1_lit", err1, 1'b1);
    chk("oor_e1dr1_lit", e1dr1, 1'b1);
    chk("oor_stb1_lit", stb1, 3'b000);
    chk("oor_stb0_lit", stb0, 4'b1000);
    chk("oor_err0_lit", err0, 1'b0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // 34-bit frame: the captured we bit (0) ends up in sr[0].
    f = {6'b0, 1'b1, 2'd1, 32'hCAFEF00E} >> 1;
    send(f, 34);
    cyc(1, 0, 0, 1, 0);
    @(negedge clk);
`ifdef JTAG_LEN_CHECK_EN
    chk("short_err_lit", err0, 1'b1);
    chk("short_stb_lit", stb0, 4'b0000);
`else
    chk("short_stb_lit", stb0, 4'b0010);
    chk("short_wr_lit", wr0[63:32], 32'hCAFEF00E);
`endif
    cyc(0, 0, 0, 0, 0);

    // 37-bit overrun: two leading bits fall off the end.
    f = {3'b0, 1'b1, 2'd0, 32'h00005A5A, 2'b11};
    send(f, 37);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Shift, pause, resume, then reset mid-frame: frame is discarded.
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0, i[0]);
    repeat (5) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 1'b1);
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("mid_rst_busy_lit", busy0, 1'b0);
    chk("mid_rst_tdo_lit", tdo0, 1'b0);
    chk("mid_rst_wr0_lit", wr0, 128'h0);
    chk("mid_rst_wr1_lit", wr1, {3{RV1}});
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 0, 0, 1, 0);
    @(negedge clk);
    chk("post_rst_stb_lit", stb0, 4'b0000);
    chk("post_rst_e1dr_lit", e1dr0, 1'b0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
